// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath control: state encodings,
// opcode constants and ALU operation codes (also consumed by the ALU control block).
package mips_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Dispatch target out of DECODE; unknown opcodes fall back to FETCH.
    function automatic state_t decode_target(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_RTYPE:     nxt = S_EXEC;
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_BEQ:       nxt = S_BRANCH;
            OP_J:         nxt = S_JUMP;
            OP_ADDI:      nxt = S_ADDIEX;
            default:      nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_mc_control.sv
// Moore control FSM for a multi-cycle MIPS datapath. Outputs decode from the
// state register; only mem_ready (FETCH writes) and opcode (illegal flag) qualify them.
module mips_mc_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_r;
    state_t next_s;

    assign state = state_r;

    // State register; reset parks in IDLE so every output is 0 asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and output decode.
    always_comb begin
        next_s        = S_FETCH;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_op    = 1'b0;
        case (state_r)
            S_IDLE: begin
                next_s = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    next_s = S_DECODE;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                next_s     = decode_target(opcode);
                illegal_op = (next_s == S_FETCH) ? 1'b1 : 1'b0;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW) begin
                    next_s = S_MEMRD;
                end else begin
                    next_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    next_s = S_MEMWB;
                end else begin
                    next_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_s     = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    next_s = S_FETCH;
                end else begin
                    next_s = S_MEMWR;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                next_s    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                next_s    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                next_s        = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                next_s    = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                next_s    = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                next_s    = S_FETCH;
            end
            default: begin
                next_s = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_mips_mc_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_op;
    logic [3:0] state;

    mips_mc_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: mr mw iod irw pcw pcwc ps[1:0] asa asb[1:0] aop[1:0] rw rd mtr ill
    localparam logic [16:0] O_ZERO  = 17'b0_0_0_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [16:0] O_F_RDY = 17'b1_0_0_1_1_0_00_0_01_00_0_0_0_0;
    localparam logic [16:0] O_F_STL = 17'b1_0_0_0_0_0_00_0_01_00_0_0_0_0;
    localparam logic [16:0] O_DEC   = 17'b0_0_0_0_0_0_00_0_11_00_0_0_0_0;
    localparam logic [16:0] O_DECIL = 17'b0_0_0_0_0_0_00_0_11_00_0_0_0_1;
    localparam logic [16:0] O_MADR  = 17'b0_0_0_0_0_0_00_1_10_00_0_0_0_0;
    localparam logic [16:0] O_MRD   = 17'b1_0_1_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [16:0] O_MWB   = 17'b0_0_0_0_0_0_00_0_00_00_1_0_1_0;
    localparam logic [16:0] O_MWR   = 17'b0_1_1_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [16:0] O_EXEC  = 17'b0_0_0_0_0_0_00_1_00_10_0_0_0_0;
    localparam logic [16:0] O_ALUWB = 17'b0_0_0_0_0_0_00_0_00_00_1_1_0_0;
    localparam logic [16:0] O_BR    = 17'b0_0_0_0_0_1_01_1_00_01_0_0_0_0;
    localparam logic [16:0] O_JMP   = 17'b0_0_0_0_1_0_10_0_00_00_0_0_0_0;
    localparam logic [16:0] O_AIWB  = 17'b0_0_0_0_0_0_00_0_00_00_1_0_0_0;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000, BAD = 6'b111111;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] outs;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    logic [16:0] dut_outs;
    assign dut_outs = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                       pc_source, alu_src_a, alu_src_b, alu_op,
                       reg_write, reg_dst, mem_to_reg, illegal_op};

    // Monitor: pop one expectation per cycle and compare; also check exclusivity.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (state !== e.st || dut_outs !== e.outs) begin
                fails++;
                $display("FAIL cycle_check state got %0d want %0d outs got %b want %b",
                         state, e.st, dut_outs, e.outs);
            end
            tests++;
            if ((mem_write && reg_write) || (mem_read && mem_write)) begin
                fails++;
                $display("FAIL exclusivity mr=%b mw=%b rw=%b want no overlap",
                         mem_read, mem_write, reg_write);
            end
        end
    end

    task automatic cyc(input logic [5:0] op, input logic mr, input logic [3:0] st,
                       input logic [16:0] outs);
        exp_t e;
        opcode    = op;
        mem_ready = mr;
        e.st      = st;
        e.outs    = outs;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic direct(input string name, input logic [3:0] st_want,
                          input logic [16:0] outs_want);
        tests++;
        if (state !== st_want || dut_outs !== outs_want) begin
            fails++;
            $display("FAIL %s state got %0d want %0d outs got %b want %b",
                     name, state, st_want, dut_outs, outs_want);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            direct("reset_hold", 4'd0, O_ZERO);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(RT, 1'b1, 4'd0, O_ZERO);
        cyc(RT, 1'b1, 4'd1, O_F_RDY);
        // R-type
        cyc(RT, 1'b1, 4'd2, O_DEC);
        cyc(RT, 1'b1, 4'd7, O_EXEC);
        cyc(RT, 1'b1, 4'd8, O_ALUWB);
        // lw with a fetch stall then 2 MEMRD stalls
        cyc(LW, 1'b0, 4'd1, O_F_STL);
        cyc(LW, 1'b1, 4'd1, O_F_RDY);
        cyc(LW, 1'b1, 4'd2, O_DEC);
        cyc(LW, 1'b1, 4'd3, O_MADR);
        cyc(LW, 1'b0, 4'd4, O_MRD);
        cyc(LW, 1'b0, 4'd4, O_MRD);
        cyc(LW, 1'b1, 4'd4, O_MRD);
        cyc(RT, 1'b1, 4'd5, O_MWB);
        // beq
        cyc(BQ, 1'b1, 4'd1, O_F_RDY);
        cyc(BQ, 1'b1, 4'd2, O_DEC);
        cyc(RT, 1'b1, 4'd9, O_BR);
        // j
        cyc(JJ, 1'b1, 4'd1, O_F_RDY);
        cyc(JJ, 1'b1, 4'd2, O_DEC);
        cyc(RT, 1'b1, 4'd10, O_JMP);
        // addi
        cyc(AI, 1'b1, 4'd1, O_F_RDY);
        cyc(AI, 1'b1, 4'd2, O_DEC);
        cyc(AI, 1'b1, 4'd11, O_MADR);
        cyc(RT, 1'b1, 4'd12, O_AIWB);
        // illegal opcode
        cyc(BAD, 1'b1, 4'd1, O_F_RDY);
        cyc(BAD, 1'b1, 4'd2, O_DECIL);
        // sw, completes without stall
        cyc(SW, 1'b1, 4'd1, O_F_RDY);
        cyc(SW, 1'b1, 4'd2, O_DEC);
        cyc(SW, 1'b1, 4'd3, O_MADR);
        cyc(SW, 1'b1, 4'd6, O_MWR);
        // sw interrupted by reset during a MEMWR stall
        cyc(SW, 1'b1, 4'd1, O_F_RDY);
        cyc(SW, 1'b1, 4'd2, O_DEC);
        cyc(SW, 1'b1, 4'd3, O_MADR);
        cyc(SW, 1'b0, 4'd6, O_MWR);
        direct("memwr_stall", 4'd6, O_MWR);
        #2;
        rst_n = 1'b0;
        #1;
        direct("async_reset_midstore", 4'd0, O_ZERO);
        @(posedge clk);
        @(posedge clk);
        #1;
        direct("reset_held_midstore", 4'd0, O_ZERO);
        rst_n = 1'b1;
        cyc(RT, 1'b1, 4'd0, O_ZERO);
        cyc(RT, 1'b1, 4'd1, O_F_RDY);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain leftover got %0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
